mul16_seq: RTL and testbench

// - Multi-cycle 16x16 shift-add multiplier for the MUL/MULS path of the RISC datapath.
// - Sits directly upstream of the 16-bit result/HI-LO registers and drives their enable (WrEn).
// - Handles both unsigned and signed (two's complement) operands.
// - Produces a 32-bit product split into P_hi and P_lo, with a Start/Busy/Done handshake.

---
 rtl/mul16_seq_pkg.sv | 22 ++
 rtl/mul16_seq_if.sv | 26 ++
 rtl/mul16_seq.sv | 90 +++++++++
 tb/tb_mul16_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mul16_seq_pkg.sv
// Shared constants, FSM state encoding and a two's-complement magnitude
// helper for the sequential 16x16 shift-add multiplier.
package mul16_seq_pkg;

    localparam int WIDTH    = 16;
    localparam int CNT_W    = 5;
    localparam int MUL_ITER = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Magnitude of a two's-complement value; the most negative value maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/mul16_seq_if.sv
// Start/Busy/Done handshake plus operand and product buses of the multiplier.
interface mul16_seq_if
    import mul16_seq_pkg::*;
#(
    parameter int W = WIDTH
);
    logic         Start;
    logic         Signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic         WrEn;
    logic [W-1:0] P_hi;
    logic [W-1:0] P_lo;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, WrEn, P_hi, P_lo
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, WrEn, P_hi, P_lo
    );
endinterface

// File: rtl/mul16_seq.sv
// Multi-cycle 16x16 shift-add multiplier (unsigned or signed via sign/magnitude),
// 32-bit product held in registered P_hi/P_lo with a one-cycle Done/WrEn pulse.
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic         CLK,
    input  logic         CLR,
    mul16_seq_if.slave   bus
);

    state_t               state_reg;
    logic [WIDTH:0]       acc_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 neg_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     p_hi_reg;
    logic [WIDTH-1:0]     p_lo_reg;

    logic [WIDTH:0]       sum_next;
    logic [2*WIDTH-1:0]   prod_next;
    logic [2*WIDTH-1:0]   p_next;

    always_comb begin
        sum_next  = acc_reg + {1'b0, (mplier_reg[0] ? mcand_reg : '0)};
        prod_next = {acc_reg[WIDTH-1:0], mplier_reg};
        // Sign is reapplied once, after the unsigned magnitude product is complete.
        p_next    = neg_reg ? (~prod_next + (2*WIDTH)'(1)) : prod_next;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            p_hi_reg   <= '0;
            p_lo_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.Start) begin
                        mcand_reg  <= bus.Signed ? abs_val(bus.A) : bus.A;
                        mplier_reg <= bus.Signed ? abs_val(bus.B) : bus.B;
                        neg_reg    <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Accumulator and multiplier shift as one register; consumed
                    // multiplier bits make room for product low bits.
                    {acc_reg, mplier_reg} <= {sum_next, mplier_reg} >> 1;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(MUL_ITER - 1)) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    {p_hi_reg, p_lo_reg} <= p_next;
                    done_reg  <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = busy_reg;
    assign bus.Done = done_reg;
    assign bus.WrEn = done_reg;
    assign bus.P_hi = p_hi_reg;
    assign bus.P_lo = p_lo_reg;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed corners, random operands against
// an arithmetic reference, ignore/hold behaviour and reset during an operation.
module tb_mul16_seq;

    logic CLK;
    logic CLR;
    int   n_checks;
    int   n_fail;

    mul16_seq_if bus ();

    mul16_seq dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint pa;
        longint pb;
        longint p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one Start cycle, then scramble the operand inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        bus.A      = a;
        bus.B      = b;
        bus.Signed = s;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        bus.A      = 16'($urandom);
        bus.B      = 16'($urandom);
        bus.Signed = 1'($urandom);
    endtask

    // Returns the cycle index (Start cycle = 0) at which Done is seen; 60 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.Done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        n_checks += 4;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.Done); end
        if (bus.WrEn !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", bus.WrEn); end
        if ({bus.P_hi, bus.P_lo} !== 32'h0) begin
            n_fail++; $display("FAIL reset_prod got %h want 00000000", {bus.P_hi, bus.P_lo});
        end
        $display("reset: busy=%b done=%b p=%h", bus.Busy, bus.Done, {bus.P_hi, bus.P_lo});
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'd300, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF};
        logic [15:0] tb [5] = '{16'd200, 16'hFFFF, 16'h0001, 16'h8000, 16'h0003};
        logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] te [5] = '{32'h0000_EA60, 32'hFFFE_0001, 32'hFFFF_8000,
                                32'h4000_0000, 32'hFFFF_FFFD};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i], ts[i]);
            n_checks++;
            if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy got %b want 1", i, bus.Busy); end
            wait_done(cyc);
            n_checks += 5;
            if (cyc != 18) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 18", i, cyc); end
            if ({bus.P_hi, bus.P_lo} !== te[i]) begin
                n_fail++; $display("FAIL dir%0d_prod got %h want %h", i, {bus.P_hi, bus.P_lo}, te[i]);
            end
            if (te[i] !== ref_mul(ta[i], tb[i], ts[i])) begin
                n_fail++; $display("FAIL dir%0d_model got %h want %h", i, ref_mul(ta[i], tb[i], ts[i]), te[i]);
            end
            if (bus.WrEn !== 1'b1) begin n_fail++; $display("FAIL dir%0d_wren got %b want 1", i, bus.WrEn); end
            tick();
            if (bus.Done !== 1'b0 || bus.WrEn !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_pulse got done=%b wren=%b want 0", i, bus.Done, bus.WrEn);
            end
            $display("directed %0d: a=%h b=%h s=%b p=%h lat=%0d", i, ta[i], tb[i], ts[i],
                     {bus.P_hi, bus.P_lo}, cyc);
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] exp_p;
        int cyc;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            exp_p = ref_mul(a, b, s);
            start_op(a, b, s);
            wait_done(cyc);
            n_checks += 2;
            if (cyc != 18) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want 18", i, cyc); end
            if ({bus.P_hi, bus.P_lo} !== exp_p) begin
                n_fail++; $display("FAIL rnd%0d_prod a=%h b=%h s=%b got %h want %h", i, a, b, s,
                                   {bus.P_hi, bus.P_lo}, exp_p);
            end
            $display("random %0d: a=%h b=%h s=%b p=%h", i, a, b, s, {bus.P_hi, bus.P_lo});
            tick();
            if (($urandom & 1) != 0) tick();
        end
    endtask

    task automatic test_ignore_hold();
        logic [31:0] exp_p;
        int c;
        exp_p = ref_mul(16'h1234, 16'hABCD, 1'b0);
        start_op(16'h1234, 16'hABCD, 1'b0);
        c = 1;
        while (c < 18) begin
            if (c == 5) begin
                bus.A = 16'h7FFF; bus.B = 16'h7FFF; bus.Signed = 1'b1; bus.Start = 1'b1;
            end
            tick();
            bus.Start = 1'b0;
            c++;
        end
        n_checks += 2;
        if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL ign_done got %b want 1", bus.Done); end
        if ({bus.P_hi, bus.P_lo} !== exp_p) begin
            n_fail++; $display("FAIL ign_prod got %h want %h", {bus.P_hi, bus.P_lo}, exp_p);
        end
        bus.A = 16'h0003; bus.B = 16'h0005; bus.Signed = 1'b0; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks += 3;
            if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL hold%0d_busy got %b want 0", k, bus.Busy); end
            if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL hold%0d_done got %b want 0", k, bus.Done); end
            if ({bus.P_hi, bus.P_lo} !== exp_p) begin
                n_fail++; $display("FAIL hold%0d_prod got %h want %h", k, {bus.P_hi, bus.P_lo}, exp_p);
            end
        end
        $display("ignore/hold: p=%h held 10 cycles", {bus.P_hi, bus.P_lo});
    endtask

    task automatic test_reset_midop();
        logic [31:0] exp_p;
        int cyc;
        int seen;
        start_op(16'h4321, 16'h00FF, 1'b0);
        for (int k = 1; k < 9; k++) tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        n_checks += 2;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy got %b want 0", bus.Busy); end
        if ({bus.P_hi, bus.P_lo} !== 32'h0) begin
            n_fail++; $display("FAIL midclr_prod got %h want 00000000", {bus.P_hi, bus.P_lo});
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL midclr_quiet got %0d active cycles want 0", seen); end
        exp_p = ref_mul(16'hFF00, 16'h0102, 1'b1);
        start_op(16'hFF00, 16'h0102, 1'b1);
        wait_done(cyc);
        n_checks += 2;
        if (cyc != 18) begin n_fail++; $display("FAIL midclr_latency got %0d want 18", cyc); end
        if ({bus.P_hi, bus.P_lo} !== exp_p) begin
            n_fail++; $display("FAIL midclr_prod2 got %h want %h", {bus.P_hi, bus.P_lo}, exp_p);
        end
        $display("reset mid-op: restart p=%h lat=%0d", {bus.P_hi, bus.P_lo}, cyc);
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        CLR        = 1'b1;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_hold();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
